// File: rtl/mod47_disp_pkg.sv
// Shared types and constants for the mod-47 BCD converter and its 2-digit display.
// Glyphs use active-high segment order {g,f,e,d,c,b,a}.
package mod47_disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // A 6-bit input needs six shift-add-3 iterations, counted 0..5.
    localparam logic [2:0] ITER_LAST = 3'd5;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Double-dabble correction applied to a BCD nibble before each shift.
    function automatic logic [3:0] add3_if_ge5(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/mod47_bcd_display_seg7.sv
// Combinational BCD-to-seven-segment decoder, active-high output.
// Codes 10..15 and the blank request both turn every segment off.
module seg7_decoder
    import mod47_disp_pkg::*;
(
    input  logic [3:0] i_digit,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        if (!i_blank) begin
            case (i_digit)
                4'd0:    o_seg = SEG_0;
                4'd1:    o_seg = SEG_1;
                4'd2:    o_seg = SEG_2;
                4'd3:    o_seg = SEG_3;
                4'd4:    o_seg = SEG_4;
                4'd5:    o_seg = SEG_5;
                4'd6:    o_seg = SEG_6;
                4'd7:    o_seg = SEG_7;
                4'd8:    o_seg = SEG_8;
                4'd9:    o_seg = SEG_9;
                default: o_seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/mod47_bcd_display.sv
// Serial double-dabble binary-to-BCD converter feeding a registered,
// time-multiplexed 2-digit seven-segment display.
module mod47_bcd_display
    import mod47_disp_pkg::*;
#(
    parameter int REFRESH_DIV    = 1000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int BLANK_LZ       = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] bin_in,
    input  logic       bin_valid,
    output logic       busy,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic       bcd_valid,
    output logic [6:0] seg,
    output logic [1:0] an
);

    localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [6:0] SEG_RST = (SEG_ACTIVE_LOW != 0) ? ~SEG_0 : SEG_0;
    localparam logic [1:0] AN_RST  = (SEG_ACTIVE_LOW != 0) ? 2'b10 : 2'b01;

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_iter;
    logic [3:0]  r_tens, r_ones;
    logic [5:0]  r_bin;
    logic [3:0]  r_bcd_tens, r_bcd_ones;
    logic        r_bcd_valid;
    logic [13:0] w_shifted;

    // ---------------- conversion FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (bin_valid) w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (r_iter == ITER_LAST) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != ST_IDLE);
    end

    // Scratch digits are corrected first, then {tens, ones, bin} shifts as one word.
    assign w_shifted = {add3_if_ge5(r_tens), add3_if_ge5(r_ones), r_bin} << 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_iter      <= '0;
            r_tens      <= '0;
            r_ones      <= '0;
            r_bin       <= '0;
            r_bcd_tens  <= '0;
            r_bcd_ones  <= '0;
            r_bcd_valid <= 1'b0;
        end else begin
            r_bcd_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bin_valid) begin
                        r_bin  <= bin_in;
                        r_tens <= '0;
                        r_ones <= '0;
                        r_iter <= '0;
                    end
                end
                ST_SHIFT: begin
                    {r_tens, r_ones, r_bin} <= w_shifted;
                    r_iter <= r_iter + 3'd1;
                end
                ST_DONE: begin
                    r_bcd_tens  <= r_tens;
                    r_bcd_ones  <= r_ones;
                    r_bcd_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bcd_tens  = r_bcd_tens;
    assign bcd_ones  = r_bcd_ones;
    assign bcd_valid = r_bcd_valid;

    // ---------------- display multiplexer ----------------
    logic [RW-1:0] r_refresh;
    logic          r_sel;       // 0 = ones, 1 = tens
    logic          w_wrap, w_sel_nxt, w_blank;
    logic [3:0]    w_digit;
    logic [6:0]    w_seg_ah;
    logic [1:0]    w_an_ah;
    logic [6:0]    r_seg;
    logic [1:0]    r_an;

    assign w_wrap    = (r_refresh == REFRESH_LAST);
    assign w_sel_nxt = w_wrap ? ~r_sel : r_sel;
    assign w_digit   = w_sel_nxt ? r_bcd_tens : r_bcd_ones;
    assign w_blank   = w_sel_nxt && (BLANK_LZ != 0) && (r_bcd_tens == 4'd0);
    assign w_an_ah   = w_sel_nxt ? 2'b10 : 2'b01;

    seg7_decoder u_dec (
        .i_digit (w_digit),
        .i_blank (w_blank),
        .o_seg   (w_seg_ah)
    );

    // seg/an are decoded from the upcoming select so both pins move on the wrap edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_refresh <= '0;
            r_sel     <= 1'b0;
            r_seg     <= SEG_RST;
            r_an      <= AN_RST;
        end else begin
            r_refresh <= w_wrap ? '0 : r_refresh + 1'b1;
            r_sel     <= w_sel_nxt;
            r_seg     <= (SEG_ACTIVE_LOW != 0) ? ~w_seg_ah : w_seg_ah;
            r_an      <= (SEG_ACTIVE_LOW != 0) ? ~w_an_ah  : w_an_ah;
        end
    end

    assign seg = r_seg;
    assign an  = r_an;

endmodule

// File: tb/tb_mod47_bcd_display.sv
// Randomized self-checking bench for mod47_bcd_display (REFRESH_DIV=4, active-low pins).
// Expected digits come from v/10 and v%10; display from elapsed cycles since reset.
module tb_mod47_bcd_display;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] bin_in = '0;
    logic       bin_valid = 1'b0;
    logic       busy, bcd_valid;
    logic [3:0] bcd_tens, bcd_ones;
    logic [6:0] seg;
    logic [1:0] an;

    int n_checks = 0;
    int n_fail   = 0;
    int edges    = 0;
    int cur_t    = 0;
    int cur_o    = 0;

    mod47_bcd_display #(.REFRESH_DIV(DIV), .SEG_ACTIVE_LOW(1), .BLANK_LZ(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .bin_in    (bin_in),
        .bin_valid (bin_valid),
        .busy      (busy),
        .bcd_tens  (bcd_tens),
        .bcd_ones  (bcd_ones),
        .bcd_valid (bcd_valid),
        .seg       (seg),
        .an        (an)
    );

    always #5 clk = ~clk;

    // Active edges elapsed since reset was released.
    always @(posedge clk or posedge rst) begin
        if (rst) edges <= 0;
        else     edges <= edges + 1;
    end

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F;
            4: return 7'h66; 5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07;
            8: return 7'h7F; 9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // Lit digit flips every DIV edges, starting with ones; pins are active-low.
    function automatic logic [6:0] exp_seg(input int e, input int t, input int o);
        if (((e / DIV) % 2) == 1) return (t == 0) ? 7'h7F : ~glyph(t);
        return ~glyph(o);
    endfunction

    function automatic logic [1:0] exp_an(input int e);
        return (((e / DIV) % 2) == 1) ? 2'b01 : 2'b10;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bin_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
            n_checks++;
            if (bcd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bcd_valid); end
            n_checks++;
            if ({bcd_tens, bcd_ones} !== 8'h00) begin n_fail++; $display("FAIL reset_digits got=%h exp=00", {bcd_tens, bcd_ones}); end
            n_checks++;
            if (an !== 2'b10) begin n_fail++; $display("FAIL reset_an got=%b exp=10", an); end
            n_checks++;
            if (seg !== 7'b1000000) begin n_fail++; $display("FAIL reset_seg got=%b exp=1000000", seg); end
            n_checks++;
            @(negedge clk);
        end
        cur_t = 0; cur_o = 0;
    endtask

    // Single request; checks busy/valid every cycle through N+8 and the digits at N+7.
    task automatic test_convert(input logic [5:0] v, input bit rel_rst);
        int et, eo;
        et = int'(v) / 10;
        eo = int'(v) % 10;
        @(negedge clk);
        bin_in = v;
        bin_valid = 1'b1;
        if (rel_rst) rst = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            if (k == 0) bin_valid = 1'b0;
            if (busy !== 1'(k < 7)) begin n_fail++; $display("FAIL conv_busy v=%0d k=%0d got=%b exp=%b", v, k, busy, k < 7); end
            n_checks++;
            if (bcd_valid !== 1'(k == 7)) begin n_fail++; $display("FAIL conv_valid v=%0d k=%0d got=%b exp=%b", v, k, bcd_valid, k == 7); end
            n_checks++;
            if (k == 7) begin
                if (bcd_tens !== 4'(et) || bcd_ones !== 4'(eo)) begin
                    n_fail++;
                    $display("FAIL conv_digits v=%0d got=%0d,%0d exp=%0d,%0d", v, bcd_tens, bcd_ones, et, eo);
                end
                n_checks++;
            end
        end
        cur_t = et; cur_o = eo;
    endtask

    task automatic test_boundaries();
        logic [5:0] vals [5];
        vals = '{6'd46, 6'd0, 6'd9, 6'd10, 6'd63};
        foreach (vals[i]) test_convert(vals[i], 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) test_convert(6'($urandom_range(0, 63)), 1'b0);
    endtask

    // 12 then 33 with bin_valid held high: 33 accepted at N+8, no extra pulses.
    task automatic test_back_to_back();
        int pulses = 0;
        @(negedge clk);
        bin_in = 6'd12;
        bin_valid = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            if (k == 0) bin_in = 6'd33;
            if (busy !== 1'(k < 7 || (k >= 8 && k < 15))) begin
                n_fail++; $display("FAIL b2b_busy k=%0d got=%b", k, busy);
            end
            n_checks++;
            if (bcd_valid) pulses++;
            if (k == 7 && {bcd_valid, bcd_tens, bcd_ones} !== 9'h112) begin
                n_fail++; $display("FAIL b2b_first got=%b,%0d,%0d exp=1,1,2", bcd_valid, bcd_tens, bcd_ones);
            end
            if (k == 7) n_checks++;
            if (k == 15 && {bcd_valid, bcd_tens, bcd_ones} !== 9'h133) begin
                n_fail++; $display("FAIL b2b_second got=%b,%0d,%0d exp=1,3,3", bcd_valid, bcd_tens, bcd_ones);
            end
            if (k == 15) begin n_checks++; bin_valid = 1'b0; end
        end
        if (pulses != 2) begin n_fail++; $display("FAIL b2b_pulses got=%0d exp=2", pulses); end
        n_checks++;
        cur_t = 3; cur_o = 3;
    endtask

    task automatic test_display(input logic [5:0] v);
        test_convert(v, 1'b0);
        for (int k = 0; k < 3 * 2 * DIV; k++) begin
            if (an !== exp_an(edges)) begin n_fail++; $display("FAIL disp_an v=%0d e=%0d got=%b exp=%b", v, edges, an, exp_an(edges)); end
            n_checks++;
            if (seg !== exp_seg(edges, cur_t, cur_o)) begin
                n_fail++; $display("FAIL disp_seg v=%0d e=%0d got=%b exp=%b", v, edges, seg, exp_seg(edges, cur_t, cur_o));
            end
            n_checks++;
            @(negedge clk);
        end
    endtask

    // Reset asserted before edge N+3 of a conversion of 46 must abort it silently.
    task automatic test_reset_mid();
        int pulses = 0;
        @(negedge clk);
        bin_in = 6'd46;
        bin_valid = 1'b1;
        @(negedge clk);
        bin_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        n_checks++;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bcd_valid) pulses++;
        end
        if (pulses != 0) begin n_fail++; $display("FAIL rstmid_pulses got=%0d exp=0", pulses); end
        n_checks++;
        if ({busy, bcd_tens, bcd_ones} !== 9'h000) begin
            n_fail++; $display("FAIL rstmid_state got=%b,%0d,%0d exp=0,0,0", busy, bcd_tens, bcd_ones);
        end
        n_checks++;
        cur_t = 0; cur_o = 0;
        test_convert(6'd46, 1'b0);
        // Request presented in the same cycle reset releases is taken at the first edge.
        @(negedge clk);
        rst = 1'b1;
        test_convert(6'd25, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_boundaries();
        test_back_to_back();
        test_random();
        test_display(6'd46);
        test_display(6'd7);
        test_reset_mid();
        test_display(6'd59);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
